// File: rtl/core_ifu_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
// Single outstanding request: req/gnt handshake, then one rvalid beat.
interface core_ifu_if;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_gnt_i,
    input  ibus_rvalid_i,
    input  ibus_rdata_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_gnt_i,
    output ibus_rvalid_i,
    output ibus_rdata_i
  );
endinterface

// File: rtl/core_ifu.sv
// Instruction fetch unit: issues one word fetch at a time, feeds the IF/ID
// registers, and parks a returned word in a 1-entry buffer while decode stalls.
module core_ifu #(
  parameter logic [31:0] RST_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_flag_in,
  input  logic [31:0]      jump_addr_in,
  input  logic             hold_flag_in,
  core_ifu_if.master       ibus,
  output logic [31:0]      inst_addr_out,
  output logic [31:0]      inst_out,
  output logic             inst_valid_out
);

  typedef enum logic [1:0] {
    S_REQ,   // request on the bus, waiting for grant
    S_WAIT,  // granted, waiting for read data
    S_KILL,  // granted request was redirected away; drop its data
    S_BUF    // fetched word parked while decode is held
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] buf_addr, buf_addr_nxt;
  logic [31:0] buf_inst, buf_inst_nxt;
  logic [31:0] addr_nxt, inst_nxt;
  logic        valid_nxt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_REQ;
      pc             <= RST_ADDR;
      buf_addr       <= '0;
      buf_inst       <= '0;
      inst_addr_out  <= RST_ADDR;
      inst_out       <= NOP_INST;
      inst_valid_out <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      buf_addr       <= buf_addr_nxt;
      buf_inst       <= buf_inst_nxt;
      inst_addr_out  <= addr_nxt;
      inst_out       <= inst_nxt;
      inst_valid_out <= valid_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_nxt    = state;
    pc_nxt       = pc;
    buf_addr_nxt = buf_addr;
    buf_inst_nxt = buf_inst;
    addr_nxt     = inst_addr_out;
    if (hold_flag_in) begin
      inst_nxt  = inst_out;
      valid_nxt = inst_valid_out;
    end else begin
      inst_nxt  = NOP_INST;
      valid_nxt = 1'b0;
    end

    if (jump_flag_in) begin
      // Redirect wins over hold and rvalid; the parked word is stale.
      pc_nxt       = {jump_addr_in[31:2], 2'b00};
      inst_nxt     = NOP_INST;
      valid_nxt    = 1'b0;
      buf_addr_nxt = '0;
      buf_inst_nxt = '0;
      unique case (state)
        S_REQ:   state_nxt = ibus.ibus_gnt_i    ? S_KILL : S_REQ;
        S_WAIT:  state_nxt = ibus.ibus_rvalid_i ? S_REQ  : S_KILL;
        // A response landing with a repeated redirect retires the old request.
        S_KILL:  state_nxt = ibus.ibus_rvalid_i ? S_REQ  : S_KILL;
        S_BUF:   state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (ibus.ibus_gnt_i) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (ibus.ibus_rvalid_i) begin
            pc_nxt = pc + 32'd4;
            if (hold_flag_in) begin
              buf_addr_nxt = pc;
              buf_inst_nxt = ibus.ibus_rdata_i;
              state_nxt    = S_BUF;
            end else begin
              addr_nxt  = pc;
              inst_nxt  = ibus.ibus_rdata_i;
              valid_nxt = 1'b1;
              state_nxt = S_REQ;
            end
          end
        end
        S_KILL: begin
          if (ibus.ibus_rvalid_i) state_nxt = S_REQ;
        end
        S_BUF: begin
          if (!hold_flag_in) begin
            addr_nxt  = buf_addr;
            inst_nxt  = buf_inst;
            valid_nxt = 1'b1;
            state_nxt = S_REQ;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  assign ibus.ibus_req_o  = (state == S_REQ) && !rst;
  assign ibus.ibus_addr_o = pc;

endmodule
